// File: rtl/uart_work_rx.sv
// Packs NBYTES one-cycle byte strobes from the UART receiver into one work word with a valid/ack handshake.
// Optional trailing XOR checksum byte is enabled by defining UART_WORK_CHECKSUM_EN.
module uart_work_rx #(
  parameter int NBYTES = 44
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_idle,
  output logic [8*NBYTES-1:0]           work_data,
  output logic                          work_valid,
  input  logic                          work_ack,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(NBYTES+2)-1:0]   byte_cnt
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 2);

  typedef enum logic {IDLE, RECV} state_t;

  state_t       state;
  logic [W-1:0] shiftReg;
  logic [W-1:0] shiftNext;
  logic [W-1:0] loadWord;
  logic         finalByte;
  logic         packetOk;
  logic         badSum;
  logic         shiftEn;

  assign shiftNext = {shiftReg[W-9:0], rx_data};

`ifdef UART_WORK_CHECKSUM_EN
  logic [7:0] csumAcc;

  // Final strobe is the checksum byte; it is compared, never shifted into the word.
  assign finalByte = (state == RECV) && rx_valid && (byte_cnt == CW'(NBYTES));
  assign packetOk  = finalByte && (rx_data == csumAcc);
  assign badSum    = finalByte && (rx_data != csumAcc);
  assign shiftEn   = rx_valid && !finalByte;
  assign loadWord  = shiftReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      csumAcc <= 8'h00;
    end else if (state == IDLE) begin
      csumAcc <= rx_valid ? rx_data : 8'h00;
    end else if (finalByte) begin
      csumAcc <= 8'h00;
    end else if (rx_valid) begin
      csumAcc <= csumAcc ^ rx_data;
    end
  end
`else
  assign finalByte = (state == RECV) && rx_valid && (byte_cnt == CW'(NBYTES - 1));
  assign packetOk  = finalByte;
  assign badSum    = 1'b0;
  assign shiftEn   = rx_valid;
  assign loadWord  = shiftNext;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      work_data  <= '0;
      work_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      frame_err <= 1'b0;
      if (shiftEn) shiftReg <= shiftNext;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            byte_cnt <= CW'(1);
            state    <= RECV;
          end
        end
        RECV: begin
          if (finalByte) begin
            byte_cnt <= '0;
            state    <= IDLE;
            if (badSum) frame_err <= 1'b1;
          end else if (rx_valid) begin
            byte_cnt <= byte_cnt + CW'(1);
          end else if (rx_idle) begin
            // Line went quiet mid-packet: drop the partial packet so the host can resync.
            frame_err <= 1'b1;
            byte_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A same-cycle ack frees the output register for the newly completed packet.
      if (packetOk) begin
        if (!work_valid || work_ack) begin
          work_data  <= loadWord;
          work_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (work_ack) begin
        work_valid <= 1'b0;
      end
    end
  end

endmodule
